// File: rtl/clusterv_tile_sram_arbiter.sv
// Round-robin arbiter sharing one single-port tile SRAM among N_REQ requesters.
// The command launches combinationally in the grant cycle; read data returns one cycle later.
module clusterv_tile_sram_arbiter #(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned BE_W      = DATA_WIDTH / 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_write_data,
    input  logic [N_REQ*BE_W-1:0]         req_byte_en,
    input  logic [N_REQ-1:0]              req_read_en,
    input  logic [N_REQ-1:0]              req_write_en,
    output logic [N_REQ-1:0]              req_gnt,
    output logic [N_REQ-1:0]              req_rvalid,
    output logic [DATA_WIDTH-1:0]         req_read_data,
    output logic [ADDR_WIDTH-1:0]         i_addr,
    output logic [DATA_WIDTH-1:0]         i_write_data,
    output logic [BE_W-1:0]               i_byte_en,
    output logic                          i_read_en,
    output logic                          i_write_en,
    input  logic [DATA_WIDTH-1:0]         i_read_data
);

    localparam int unsigned PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CAND_W = PTR_W + 1;

    logic [N_REQ-1:0]  active;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_nxt;
    logic [PTR_W-1:0]  win;
    logic              found;
    logic [CAND_W-1:0] cand;
    logic [N_REQ-1:0]  rd_owner;

    assign active = req_read_en | req_write_en;

    // First active requester scanning from ptr upward, wrapping mod N_REQ.
    always_comb begin : pick_winner
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            cand = {1'b0, ptr} + CAND_W'(j);
            if (cand >= CAND_W'(N_REQ)) begin
                cand = cand - CAND_W'(N_REQ);
            end
            if (!found && active[cand[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = cand[PTR_W-1:0];
            end
        end
    end

    // Winner's command onto the SRAM port; a write wins over a read from the same requester.
    always_comb begin : drive_sram
        req_gnt      = '0;
        i_addr       = '0;
        i_write_data = '0;
        i_byte_en    = '0;
        i_read_en    = 1'b0;
        i_write_en   = 1'b0;
        if (found) begin
            req_gnt[win] = 1'b1;
            i_write_en   = req_write_en[win];
            i_read_en    = req_read_en[win] & ~req_write_en[win];
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (PTR_W'(i) == win) begin
                    i_addr       = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    i_write_data = req_write_data[i*DATA_WIDTH +: DATA_WIDTH];
                    i_byte_en    = req_byte_en[i*BE_W +: BE_W];
                end
            end
        end
    end

    always_comb begin : next_ptr
        ptr_nxt = ptr;
        if (found) begin
            ptr_nxt = (win == PTR_W'(N_REQ - 1)) ? '0 : win + PTR_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin : state_reg
        if (reset) begin
            ptr      <= '0;
            rd_owner <= '0;
        end else begin
            ptr      <= ptr_nxt;
            rd_owner <= i_read_en ? req_gnt : '0;
        end
    end

    assign req_rvalid    = rd_owner;
    assign req_read_data = i_read_data;

endmodule
